// File: rtl/sha_block_sequencer.sv
// Feeds 512-bit padded blocks to a SHA-256 core as sixteen 32-bit words,
// tracks per-message block count, and flags overflow or core timeout.
module sha_block_sequencer #(
  parameter int unsigned TIMEOUT = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         blk_ready,
  input  logic         pad_overflow,
  output logic         word_valid,
  output logic [31:0]  word_data,
  output logic [3:0]   word_idx,
  output logic         word_first,
  input  logic         word_ready,
  input  logic         core_done,
  output logic         msg_done,
  output logic [7:0]   blk_count,
  output logic         err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [511:0]   shift_q, shift_d;
  logic [3:0]     idx_q, idx_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           msg_done_q, msg_done_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    first_d    = first_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    msg_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Overflow beats a simultaneous block offer: nothing is captured.
        if (pad_overflow) begin
          state_d = ST_ERR;
        end else if (blk_valid) begin
          shift_d = blk_data;
          last_d  = blk_last;
          first_d = (cnt_q == 8'd0);
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pad_overflow) begin
          state_d = ST_ERR;
        end else if (word_ready) begin
          shift_d = {shift_q[479:0], 32'h0};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            tmo_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (pad_overflow) begin
          state_d = ST_ERR;
        end else if (core_done) begin
          if (last_q) begin
            msg_done_d = 1'b1;
            cnt_d      = 8'd0;
          end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
          state_d = ST_IDLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      msg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      msg_done_q <= msg_done_d;
    end
  end

  assign blk_ready  = (state_q == ST_IDLE);
  assign word_valid = (state_q == ST_SEND);
  assign word_data  = shift_q[511:480];
  assign word_idx   = idx_q;
  assign word_first = first_q && (state_q == ST_SEND);
  assign msg_done   = msg_done_q;
  assign blk_count  = cnt_q;
  assign err        = (state_q == ST_ERR);

endmodule
